// File: rtl/hazard_stall_controller_if.sv
// Control bundle between the ID/EX pipeline and the hazard/stall controller.
// The controller sits on the slave side; the pipeline drives the master side.
interface hazard_stall_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             use_rs1_ID;
    logic             use_rs2_ID;
    logic [4:0]       rd_EX;
    logic             MemRead_EX;
    logic             branch_taken_EX;
    logic             mdu_start_EX;
    logic             mdu_done;
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             bubble_ex_mem;
    logic             mdu_busy;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
               branch_taken_EX, mdu_start_EX, mdu_done,
        input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               bubble_ex_mem, mdu_busy, mdu_timeout, stall_count, flush_count
    );

    modport slave (
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
               branch_taken_EX, mdu_start_EX, mdu_done,
        output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               bubble_ex_mem, mdu_busy, mdu_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use bubble insertion, MDU front-end freeze with timeout, branch squash,
// and saturating stall/flush performance counters for the 5-stage core.
module hazard_stall_controller #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input logic                     clk,
    input logic                     rst,
    hazard_stall_controller_if.slave hz
);
    localparam int unsigned WAIT_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MDU_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_BUSY = 2'b01
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_pc, stall_if_id, stall_id_ex;
    logic flush_if_id, flush_id_ex, bubble_ex_mem, mdu_timeout;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        load_use = hz.MemRead_EX && (hz.rd_EX != 5'd0) &&
                   ((hz.use_rs1_ID && (hz.rd_EX == hz.rs1_ID)) ||
                    (hz.use_rs2_ID && (hz.rd_EX == hz.rs2_ID)));
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        mdu_timeout   = 1'b0;

        if (rst) begin
            state_d = RUN;
            wait_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.mdu_start_EX) begin
                        if (!hz.mdu_done) begin
                            stall_pc      = 1'b1;
                            stall_if_id   = 1'b1;
                            stall_id_ex   = 1'b1;
                            bubble_ex_mem = 1'b1;
                            state_d       = MDU_BUSY;
                            wait_d        = WAIT_W'(1);
                        end
                    end else if (hz.branch_taken_EX) begin
                        // the load-use consumer is squashed, so no stall needed
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (hz.mdu_done) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end else if (wait_q < WAIT_MAX) begin
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_ex   = 1'b1;
                        bubble_ex_mem = 1'b1;
                        wait_d        = wait_q + WAIT_W'(1);
                    end else begin
                        mdu_timeout = 1'b1;
                        state_d     = RUN;
                        wait_d      = '0;
                    end
                end
                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_pc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_if_id && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        wait_q      <= wait_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    always_comb begin
        hz.stall_pc      = stall_pc;
        hz.stall_if_id   = stall_if_id;
        hz.stall_id_ex   = stall_id_ex;
        hz.flush_if_id   = flush_if_id;
        hz.flush_id_ex   = flush_id_ex;
        hz.bubble_ex_mem = bubble_ex_mem;
        hz.mdu_timeout   = mdu_timeout;
        hz.mdu_busy      = (state_q == MDU_BUSY);
        hz.stall_count   = stall_cnt_q;
        hz.flush_count   = flush_cnt_q;
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller with MDU_TIMEOUT=8 and a
// 3-bit counter width so saturation is reachable in a short run.
module tb_hazard_stall_controller;
    logic clk;
    logic rst;
    int unsigned n_vec;
    int unsigned n_err;

    hazard_stall_controller_if #(.CNT_W(3)) hz ();

    hazard_stall_controller #(
        .MDU_TIMEOUT(8),
        .CNT_W      (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble_ex_mem, mdu_timeout}
    logic [6:0] ctl;
    assign ctl = {hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.flush_if_id,
                  hz.flush_id_ex, hz.bubble_ex_mem, hz.mdu_timeout};

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_BR    = 7'b0001100;
    localparam logic [6:0] C_MDU   = 7'b1110010;
    localparam logic [6:0] C_TMO   = 7'b0000001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.rs1_ID          = 5'd0;
        hz.rs2_ID          = 5'd0;
        hz.use_rs1_ID      = 1'b0;
        hz.use_rs2_ID      = 1'b0;
        hz.rd_EX           = 5'd0;
        hz.MemRead_EX      = 1'b0;
        hz.branch_taken_EX = 1'b0;
        hz.mdu_start_EX    = 1'b0;
        hz.mdu_done        = 1'b0;
    endtask

    task automatic load_use_rs2(input logic [4:0] r);
        idle();
        hz.MemRead_EX = 1'b1;
        hz.rd_EX      = r;
        hz.rs2_ID     = r;
        hz.use_rs2_ID = 1'b1;
        hz.rs1_ID     = 5'd3;
        hz.use_rs1_ID = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            hz.rs1_ID          = 5'($urandom);
            hz.rs2_ID          = 5'($urandom);
            hz.use_rs1_ID      = 1'($urandom);
            hz.use_rs2_ID      = 1'($urandom);
            hz.rd_EX           = 5'($urandom);
            hz.MemRead_EX      = 1'($urandom);
            hz.branch_taken_EX = 1'($urandom);
            hz.mdu_start_EX    = 1'($urandom);
            hz.mdu_done        = 1'($urandom);
            #1;
            check($sformatf("rst_ctl%0d", i), 32'(ctl), 32'(C_NONE));
            tick();
        end
        check("rst_busy", 32'(hz.mdu_busy), 32'd0);
        check("rst_scnt", 32'(hz.stall_count), 32'd0);
        check("rst_fcnt", 32'(hz.flush_count), 32'd0);

        // load-use on rs2
        rst = 1'b0;
        load_use_rs2(5'd5);
        #1;
        check("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_scnt", 32'(hz.stall_count), 32'd1);
        hz.MemRead_EX = 1'b0;
        #1;
        check("lu_clear", 32'(ctl), 32'(C_NONE));
        tick();

        // x0 never hazards; unused source never hazards
        load_use_rs2(5'd0);
        #1;
        check("lu_x0", 32'(ctl), 32'(C_NONE));
        tick();
        load_use_rs2(5'd9);
        hz.use_rs2_ID = 1'b0;
        #1;
        check("lu_unused", 32'(ctl), 32'(C_NONE));
        tick();
        check("lu_x0_scnt", 32'(hz.stall_count), 32'd1);

        // load-use on rs1
        idle();
        hz.MemRead_EX = 1'b1;
        hz.rd_EX      = 5'd7;
        hz.rs1_ID     = 5'd7;
        hz.use_rs1_ID = 1'b1;
        #1;
        check("lu_rs1", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_rs1_scnt", 32'(hz.stall_count), 32'd2);

        // branch beats a simultaneous load-use
        load_use_rs2(5'd5);
        hz.branch_taken_EX = 1'b1;
        #1;
        check("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        #1;
        check("br_fcnt", 32'(hz.flush_count), 32'd1);
        check("br_scnt", 32'(hz.stall_count), 32'd2);
        check("br_after", 32'(ctl), 32'(C_NONE));
        tick();

        // single-cycle MDU completion: no stall, stays in RUN
        hz.mdu_start_EX = 1'b1;
        hz.mdu_done     = 1'b1;
        #1;
        check("mdu1_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        idle();
        #1;
        check("mdu1_busy", 32'(hz.mdu_busy), 32'd0);

        // MDU completes on the 4th cycle after start
        hz.mdu_start_EX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mdu_ctl%0d", i), 32'(ctl), 32'(C_MDU));
            check($sformatf("mdu_busy%0d", i), 32'(hz.mdu_busy), (i > 0) ? 32'd1 : 32'd0);
            tick();
        end
        hz.mdu_done = 1'b1;
        #1;
        check("mdu_done_ctl", 32'(ctl), 32'(C_NONE));
        check("mdu_done_busy", 32'(hz.mdu_busy), 32'd1);
        tick();
        idle();
        #1;
        check("mdu_run_busy", 32'(hz.mdu_busy), 32'd0);
        check("mdu_scnt", 32'(hz.stall_count), 32'd6);
        tick();

        // timeout: 8 stall cycles then a one-cycle pulse; counter saturates at 7
        hz.mdu_start_EX = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("tmo_ctl%0d", i), 32'(ctl), 32'(C_MDU));
            tick();
        end
        #1;
        check("tmo_pulse", 32'(ctl), 32'(C_TMO));
        check("tmo_busy", 32'(hz.mdu_busy), 32'd1);
        tick();
        idle();
        #1;
        check("tmo_run", 32'(hz.mdu_busy), 32'd0);
        check("tmo_after", 32'(ctl), 32'(C_NONE));
        check("tmo_scnt_sat", 32'(hz.stall_count), 32'd7);
        tick();

        // done coincident with timeout wins; branch/load-use ignored while busy
        hz.mdu_start_EX = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("dt_ctl%0d", i), 32'(ctl), 32'(C_MDU));
            tick();
            if (i == 0) begin
                load_use_rs2(5'd4);
                hz.branch_taken_EX = 1'b1;
                hz.mdu_start_EX    = 1'b1;
            end
        end
        hz.mdu_done = 1'b1;
        #1;
        check("dt_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        idle();
        #1;
        check("dt_busy", 32'(hz.mdu_busy), 32'd0);
        check("dt_fcnt", 32'(hz.flush_count), 32'd1);
        tick();

        // counter saturation at CNT_W=3 after 9 load-use events
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_scnt", 32'(hz.stall_count), 32'd0);
        for (int i = 0; i < 9; i++) begin
            load_use_rs2(5'd5);
            tick();
            idle();
            tick();
        end
        check("sat_scnt", 32'(hz.stall_count), 32'd7);
        check("sat_fcnt", 32'(hz.flush_count), 32'd0);

        // reset mid-MDU abandons the wait without a timeout pulse
        hz.mdu_start_EX = 1'b1;
        tick();
        tick();
        tick();
        check("rmid_busy", 32'(hz.mdu_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rmid_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rmid_busy_after", 32'(hz.mdu_busy), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                #1;
                if (ctl != C_NONE) seen = 1'b1;
                tick();
            end
            check("rmid_quiet", 32'(seen), 32'd0);
        end
        check("rmid_scnt", 32'(hz.stall_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
